conv1d_engine: RTL
==================

# conv1d_engine

Datapath and sequencer of the conv1d accelerator, sitting directly below the control-register block: it consumes the decoded configuration (start, lengths, kernel, base addresses) and produces the completion event the wrapper turns into its interrupt. It streams input samples from the accelerator's local SRAM port, slides them through a tap window, computes one fixed-point dot product per output position, and writes results back to the same SRAM. One output is produced every 3 cycles after a window-fill phase.

## Interface

- DATA_W, 16: signed sample/coefficient width
- ACC_W, 32: signed accumulator width
- MAX_TAPS, 8: maximum kernel length
- ADDR_W, 10: SRAM word-address width
- clk_i  in  1  clock; the block uses one clock only
- rst_i  in  1  reset; synchronous and active-high
- start_i  in  1  single-cycle start pulse
- in_len_i  in  ADDR_W  number of input samples
- taps_i  in  4  kernel length T, legal range 1..MAX_TAPS
- shift_i  in  5  arithmetic right shift applied to the accumulator
- in_base_i / out_base_i  in  ADDR_W  SRAM word addresses of the input and output vectors
- kernel_i  in  MAX_TAPS*DATA_W  coefficients; k[j] = bits [j*DATA_W +: DATA_W]
- mem_req_o, mem_we_o  out  1  SRAM request / write enable
- mem_addr_o  out  ADDR_W  SRAM word address
- mem_wdata_o  out  32  write data
- mem_rdata_i  in  32  read data, valid exactly 1 cycle after a read request; sample = bits [DATA_W-1:0]
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  configuration error flag for the last operation

## Operation

- States: IDLE, RD, SH, WR, DONE.
- IDLE: start_i latches all configuration inputs. Configuration inputs are ignored at all other times.
- Start validity check: if T==0, T>MAX_TAPS, or in_len<T:
  - go to DONE with err_o=1;
  - no memory access is made.
- Otherwise:
  - N = in_len-T+1 outputs;
  - clear the window, read pointer rp=in_base, write pointer wp=out_base;
  - clear err_o;
  - go to RD.
- RD: mem_req_o=1, mem_we_o=0, mem_addr_o=rp; rp++. Then go to SH.
- SH: window shift: w[0]<=mem_rdata_i[DATA_W-1:0], w[n]<=w[n-1]. Sample counter++. Then:
  - if fewer than T samples have been loaded, go to RD;
  - otherwise go to WR.
- WR:
  - acc = Σ_{j=0}^{T-1} k[j]·w[T-1-j], computed in ACC_W signed;
  - r = acc >>> shift_i;
  - r is saturated to DATA_W signed, then sign-extended to 32 bits onto mem_wdata_o;
  - mem_req_o=1, mem_we_o=1, mem_addr_o=wp; wp++.
  - Next state: RD if outputs remain, else DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Address pointers wrap modulo 2^ADDR_W. Products are DATA_W×DATA_W signed, summed without intermediate saturation; overflow beyond ACC_W wraps.
- start_i while busy_o=1 is ignored.
- rst_i mid-operation:
  - go to IDLE the next cycle;
  - the pending write is dropped;
  - mem_req_o=0 during and after reset.

## Timing

- Reset values: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0.
- Cycle c0 = start_i sampled. First RD is in c0+1.
- Fill phase costs 2(T-1) cycles. Each output costs 3 cycles (RD, SH, WR).
- done_o is asserted in cycle c0+2(T-1)+3N+1.
- Error case: done_o=1 and err_o=1 in c0+1.
- busy_o=1 from c0+1 up to and including the DONE cycle.
- err_o holds its value until the next accepted start.
- All memory outputs are registered-state decodes: mem_req_o=0 in IDLE, SH and DONE.

## Configuration

- Macro CONV1D_ENGINE_SAT_EN.
- Defined: the shifted result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before sign extension.
- Undefined: the low DATA_W bits of r are taken (two's-complement wrap), then sign-extended. No clamp logic is generated.

## Test plan

- T=3, k={1,1,1}, shift=0, input 1,2,3,4,5 at in_base=0x10, out_base=0x40:
  - words 6, 9, 12 written to 0x40..0x42;
  - done_o in c0+14, err_o=0.
- T=1, k={0x7FFF}, shift=0, input 0x7FFF:
  - with CONV1D_ENGINE_SAT_EN, writes 0x00007FFF;
  - without it, writes 0x00000001.
- T=1, k={2}, shift=1, input 0xFFFD (−3): writes 0xFFFFFFFD.
- in_len=2, T=3:
  - done_o and err_o in c0+1;
  - mem_req_o never asserted.
- T=2, in_len=6, with rst_i pulsed during the second WR:
  - only the first output is written;
  - busy_o=0 and mem_req_o=0 the cycle after reset;
  - a following valid start completes normally.
- Second start_i pulse while busy: ignored; output count and done timing unchanged.

Source files
------------

// File: rtl/conv1d_engine.sv
// conv1d_engine: streaming 1-D convolution sequencer and datapath over a shared SRAM port.
// Define CONV1D_ENGINE_SAT_EN to clamp results to DATA_W signed; otherwise results wrap.
module conv1d_engine #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int MAX_TAPS = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [ADDR_W-1:0]          in_len_i,
    input  logic [3:0]                 taps_i,
    input  logic [4:0]                 shift_i,
    input  logic [ADDR_W-1:0]          in_base_i,
    input  logic [ADDR_W-1:0]          out_base_i,
    input  logic [MAX_TAPS*DATA_W-1:0] kernel_i,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [31:0]                mem_wdata_o,
    input  logic [31:0]                mem_rdata_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] SH   = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam int IW = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    logic [2:0]                 state_q, state_d;
    logic [ADDR_W-1:0]          rp_q, rp_d, wp_q, wp_d, left_q, left_d;
    logic [3:0]                 taps_q, taps_d, fill_q, fill_d;
    logic [4:0]                 shift_q, shift_d;
    logic [MAX_TAPS*DATA_W-1:0] kern_q, kern_d;
    logic signed [DATA_W-1:0]   win_q [MAX_TAPS];
    logic signed [DATA_W-1:0]   win_d [MAX_TAPS];
    logic                       err_q, err_d;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc, res;
    logic [IW-1:0]              idx;
    logic [DATA_W-1:0]          sat;
    logic                       cfg_bad;
    logic                       unused_rdata;

    assign unused_rdata = ^mem_rdata_i[31:DATA_W];
    assign cfg_bad = (taps_i == 4'd0) || ({1'b0, taps_i} > 5'(MAX_TAPS)) || (in_len_i < ADDR_W'(taps_i));

    // Newest sample sits in win_q[0], so k[j] pairs with win_q[T-1-j].
    always_comb begin
        acc  = '0;
        prod = '0;
        idx  = '0;
        for (int j = 0; j < MAX_TAPS; j++) begin
            if (j < int'(taps_q)) begin
                idx  = IW'(int'(taps_q) - 1 - j);
                prod = $signed(kern_q[j*DATA_W +: DATA_W]) * win_q[idx];
                acc  = acc + ACC_W'(prod);
            end
        end
        res = acc >>> shift_q;
    end

`ifdef CONV1D_ENGINE_SAT_EN
    assign sat = (res > SAT_HI) ? SAT_HI[DATA_W-1:0] : (res < SAT_LO) ? SAT_LO[DATA_W-1:0] : res[DATA_W-1:0];
`else
    assign sat = res[DATA_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        left_d  = left_q;
        taps_d  = taps_q;
        fill_d  = fill_q;
        shift_d = shift_q;
        kern_d  = kern_q;
        err_d   = err_q;
        win_d   = win_q;
        case (state_q)
            IDLE: if (start_i) begin
                taps_d  = taps_i;
                shift_d = shift_i;
                kern_d  = kernel_i;
                rp_d    = in_base_i;
                wp_d    = out_base_i;
                left_d  = in_len_i - ADDR_W'(taps_i) + ADDR_W'(1);
                fill_d  = '0;
                err_d   = cfg_bad;
                for (int n = 0; n < MAX_TAPS; n++) win_d[n] = '0;
                state_d = cfg_bad ? DONE : RD;
            end
            RD: begin
                rp_d    = rp_q + ADDR_W'(1);
                state_d = SH;
            end
            SH: begin
                win_d[0] = mem_rdata_i[DATA_W-1:0];
                for (int n = 1; n < MAX_TAPS; n++) win_d[n] = win_q[n-1];
                fill_d  = (fill_q < taps_q) ? fill_q + 4'd1 : fill_q;
                state_d = (fill_q + 4'd1 < taps_q) ? RD : WR;
            end
            WR: begin
                wp_d    = wp_q + ADDR_W'(1);
                left_d  = left_q - ADDR_W'(1);
                state_d = (left_q == ADDR_W'(1)) ? DONE : RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rp_q    <= '0;
            wp_q    <= '0;
            left_q  <= '0;
            taps_q  <= '0;
            fill_q  <= '0;
            shift_q <= '0;
            kern_q  <= '0;
            err_q   <= 1'b0;
            for (int n = 0; n < MAX_TAPS; n++) win_q[n] <= '0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            left_q  <= left_d;
            taps_q  <= taps_d;
            fill_q  <= fill_d;
            shift_q <= shift_d;
            kern_q  <= kern_d;
            err_q   <= err_d;
            win_q   <= win_d;
        end
    end

    // Reset gates the request so an in-flight write is dropped in the reset cycle.
    assign mem_req_o   = !rst_i && (state_q == RD || state_q == WR);
    assign mem_we_o    = !rst_i && (state_q == WR);
    assign mem_addr_o  = (state_q == WR) ? wp_q : (state_q == RD) ? rp_q : '0;
    assign mem_wdata_o = (state_q == WR) ? {{(32-DATA_W){sat[DATA_W-1]}}, sat} : 32'd0;
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign err_o       = err_q;
endmodule
